mem_read_arbiter: RTL and testbench

MEM_READ_ARBITER -- requirements
Module: mem_read_arbiter

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/mem_arb_pick.sv | 34 +++
 rtl/mem_read_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_read_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and requester ids for the memory read arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef logic req_id_t;

    localparam req_id_t REQ_FETCH = 1'b0;
    localparam req_id_t REQ_DATA  = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between the fetch and data requesters.
// MEM_ARB_FETCH_PRIORITY_EN: fetch always wins ties; otherwise round-robin on last_grant.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic    f_valid,
    input  logic    d_valid,
    input  req_id_t last_grant,
    output logic    grant_valid,
    output req_id_t grant_id
);

`ifdef MEM_ARB_FETCH_PRIORITY_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        grant_valid = f_valid | d_valid;
        grant_id    = f_valid ? REQ_FETCH : REQ_DATA;
    end
`else
    always_comb begin
        grant_valid = f_valid | d_valid;
        grant_id    = REQ_FETCH;
        // On a tie the requester not served last goes first.
        if (f_valid && d_valid) begin
            grant_id = (last_grant == REQ_DATA) ? REQ_FETCH : REQ_DATA;
        end else if (d_valid) begin
            grant_id = REQ_DATA;
        end
    end
`endif

endmodule

// File: rtl/mem_read_arbiter.sv
// Two-requester (fetch/data) arbiter onto one memory read port, one transaction in flight.
// Optional macro MEM_ARB_FETCH_PRIORITY_EN selects fixed fetch priority on ties.
module mem_read_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 64,
    parameter int BUFFER_SIZE = 512
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic [ADDR_WIDTH-1:0]  F_R_ADDR,
    input  logic                   F_R_ADDR_VALID,
    output logic [BUFFER_SIZE-1:0] F_R_DATA,
    output logic                   F_R_DATA_VALID,

    input  logic [ADDR_WIDTH-1:0]  D_R_ADDR,
    input  logic                   D_R_ADDR_VALID,
    output logic [BUFFER_SIZE-1:0] D_R_DATA,
    output logic                   D_R_DATA_VALID,

    output logic [ADDR_WIDTH-1:0]  M_R_ADDR,
    output logic                   M_R_ADDR_VALID,
    input  logic [BUFFER_SIZE-1:0] M_R_DATA,
    input  logic                   M_R_DATA_VALID,

    output logic                   BUSY
);

    state_e                 state_q, state_d;
    req_id_t                owner_q, owner_d;
    req_id_t                last_grant_q, last_grant_d;
    logic [ADDR_WIDTH-1:0]  m_addr_q, m_addr_d;
    logic                   m_addr_valid_q, m_addr_valid_d;
    logic [BUFFER_SIZE-1:0] f_data_q, f_data_d;
    logic                   f_valid_q, f_valid_d;
    logic [BUFFER_SIZE-1:0] d_data_q, d_data_d;
    logic                   d_valid_q, d_valid_d;

    logic                   grant_valid;
    req_id_t                grant_id;

    mem_arb_pick u_pick (
        .f_valid     (F_R_ADDR_VALID),
        .d_valid     (D_R_ADDR_VALID),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            owner_q        <= REQ_FETCH;
            last_grant_q   <= REQ_DATA;
            m_addr_q       <= '0;
            m_addr_valid_q <= 1'b0;
            f_data_q       <= '0;
            f_valid_q      <= 1'b0;
            d_data_q       <= '0;
            d_valid_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            last_grant_q   <= last_grant_d;
            m_addr_q       <= m_addr_d;
            m_addr_valid_q <= m_addr_valid_d;
            f_data_q       <= f_data_d;
            f_valid_q      <= f_valid_d;
            d_data_q       <= d_data_d;
            d_valid_q      <= d_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_valid) state_d = WAIT;
            WAIT:    if (M_R_DATA_VALID) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Response pulses default low, so RESP clears them on its single edge.
    always_comb begin
        owner_d        = owner_q;
        last_grant_d   = last_grant_q;
        m_addr_d       = m_addr_q;
        m_addr_valid_d = m_addr_valid_q;
        f_data_d       = f_data_q;
        f_valid_d      = 1'b0;
        d_data_d       = d_data_q;
        d_valid_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    m_addr_d       = (grant_id == REQ_FETCH) ? F_R_ADDR : D_R_ADDR;
                    m_addr_valid_d = 1'b1;
                    owner_d        = grant_id;
                    last_grant_d   = grant_id;
                end
            end
            WAIT: begin
                if (M_R_DATA_VALID) begin
                    m_addr_d       = '0;
                    m_addr_valid_d = 1'b0;
                    if (owner_q == REQ_FETCH) begin
                        f_data_d  = M_R_DATA;
                        f_valid_d = 1'b1;
                    end else begin
                        d_data_d  = M_R_DATA;
                        d_valid_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        F_R_DATA       = f_data_q;
        F_R_DATA_VALID = f_valid_q;
        D_R_DATA       = d_data_q;
        D_R_DATA_VALID = d_valid_q;
        M_R_ADDR       = m_addr_q;
        M_R_ADDR_VALID = m_addr_valid_q;
        BUSY           = (state_q != IDLE);
    end

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Directed self-checking bench for mem_read_arbiter (default 64-bit address, 512-bit line).
module tb_mem_read_arbiter;

    localparam int AW = 64;
    localparam int BW = 512;

    logic          clk;
    logic          reset;
    logic [AW-1:0] F_R_ADDR, D_R_ADDR, M_R_ADDR;
    logic          F_R_ADDR_VALID, D_R_ADDR_VALID, M_R_ADDR_VALID;
    logic [BW-1:0] F_R_DATA, D_R_DATA, M_R_DATA;
    logic          F_R_DATA_VALID, D_R_DATA_VALID, M_R_DATA_VALID;
    logic          BUSY;

    int checks = 0;
    int errors = 0;

    logic [BW-1:0] f_exp, d_exp;
    logic [BW-1:0] line_aa, line_11, line_22, line_33, line_55, line_66, line_77;

    mem_read_arbiter #(.ADDR_WIDTH(AW), .BUFFER_SIZE(BW)) dut (
        .clk            (clk),
        .reset          (reset),
        .F_R_ADDR       (F_R_ADDR),
        .F_R_ADDR_VALID (F_R_ADDR_VALID),
        .F_R_DATA       (F_R_DATA),
        .F_R_DATA_VALID (F_R_DATA_VALID),
        .D_R_ADDR       (D_R_ADDR),
        .D_R_ADDR_VALID (D_R_ADDR_VALID),
        .D_R_DATA       (D_R_DATA),
        .D_R_DATA_VALID (D_R_DATA_VALID),
        .M_R_ADDR       (M_R_ADDR),
        .M_R_ADDR_VALID (M_R_ADDR_VALID),
        .M_R_DATA       (M_R_DATA),
        .M_R_DATA_VALID (M_R_DATA_VALID),
        .BUSY           (BUSY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_f_vld"}, F_R_DATA_VALID, 0);
        check_eq({tag, "_d_vld"}, D_R_DATA_VALID, 0);
        check_eq({tag, "_m_vld"}, M_R_ADDR_VALID, 0);
        check_eq({tag, "_m_addr"}, M_R_ADDR, 0);
        check_eq({tag, "_busy"}, BUSY, 0);
    endtask

    task automatic do_reset();
        reset          = 1'b0;
        F_R_ADDR_VALID = 1'b0;
        D_R_ADDR_VALID = 1'b0;
        M_R_DATA_VALID = 1'b0;
        tick();
        reset = 1'b1;
        f_exp = '0;
        d_exp = '0;
    endtask

    // Grant edge, one wait cycle, then a response edge; leaves the bench just after the response edge.
    task automatic do_xact(input string tag, input logic [AW-1:0] exp_addr, input logic [BW-1:0] line);
        tick();
        check_eq({tag, "_m_addr"}, M_R_ADDR, exp_addr);
        check_eq({tag, "_m_vld"}, M_R_ADDR_VALID, 1);
        check_eq({tag, "_busy"}, BUSY, 1);
        tick();
        M_R_DATA       = line;
        M_R_DATA_VALID = 1'b1;
        tick();
        M_R_DATA_VALID = 1'b0;
        check_eq({tag, "_m_vld_clr"}, M_R_ADDR_VALID, 0);
        check_eq({tag, "_m_addr_clr"}, M_R_ADDR, 0);
    endtask

    initial begin
        line_aa = {64{8'hAA}};
        line_11 = {64{8'h11}};
        line_22 = {64{8'h22}};
        line_33 = {64{8'h33}};
        line_55 = {64{8'h55}};
        line_66 = {64{8'h66}};
        line_77 = {64{8'h77}};
        F_R_ADDR = '0;
        D_R_ADDR = '0;
        M_R_DATA = '0;
        F_R_ADDR_VALID = 1'b0;
        D_R_ADDR_VALID = 1'b0;
        M_R_DATA_VALID = 1'b0;
        reset = 1'b0;
        f_exp = '0;
        d_exp = '0;

        tick();
        tick();
        check_idle_outputs("rst");
        check_eq("rst_f_data", F_R_DATA, 0);
        check_eq("rst_d_data", D_R_DATA, 0);
        reset = 1'b1;

        // Fetch only, memory answers three cycles after the grant
        F_R_ADDR       = 64'h1000;
        F_R_ADDR_VALID = 1'b1;
        tick();
        check_eq("f1_m_addr", M_R_ADDR, 64'h1000);
        check_eq("f1_m_vld", M_R_ADDR_VALID, 1);
        check_eq("f1_busy", BUSY, 1);
        tick();
        tick();
        M_R_DATA       = line_aa;
        M_R_DATA_VALID = 1'b1;
        tick();
        M_R_DATA_VALID = 1'b0;
        F_R_ADDR_VALID = 1'b0;
        check_eq("f1_f_vld", F_R_DATA_VALID, 1);
        check_eq("f1_f_data", F_R_DATA, line_aa);
        check_eq("f1_d_vld", D_R_DATA_VALID, 0);
        check_eq("f1_m_vld_clr", M_R_ADDR_VALID, 0);
        check_eq("f1_m_addr_clr", M_R_ADDR, 0);
        check_eq("f1_busy_resp", BUSY, 1);
        tick();
        check_eq("f1_f_vld_end", F_R_DATA_VALID, 0);
        check_eq("f1_busy_end", BUSY, 0);
        check_eq("f1_f_data_hold", F_R_DATA, line_aa);

        // Both requesters held valid across three transactions
        do_reset();
        F_R_ADDR = 64'h40;
        D_R_ADDR = 64'h80;
        F_R_ADDR_VALID = 1'b1;
        D_R_ADDR_VALID = 1'b1;
        do_xact("rr1", 64'h40, line_11);
        f_exp = line_11;
        check_eq("rr1_f_vld", F_R_DATA_VALID, 1);
        check_eq("rr1_d_vld", D_R_DATA_VALID, 0);
        check_eq("rr1_f_data", F_R_DATA, f_exp);
        check_eq("rr1_d_data", D_R_DATA, d_exp);
        tick();
`ifdef MEM_ARB_FETCH_PRIORITY_EN
        do_xact("rr2", 64'h40, line_22);
        f_exp = line_22;
        check_eq("rr2_f_vld", F_R_DATA_VALID, 1);
        check_eq("rr2_d_vld", D_R_DATA_VALID, 0);
`else
        do_xact("rr2", 64'h80, line_22);
        d_exp = line_22;
        check_eq("rr2_f_vld", F_R_DATA_VALID, 0);
        check_eq("rr2_d_vld", D_R_DATA_VALID, 1);
`endif
        check_eq("rr2_f_data", F_R_DATA, f_exp);
        check_eq("rr2_d_data", D_R_DATA, d_exp);
        tick();
        do_xact("rr3", 64'h40, line_33);
        f_exp = line_33;
        check_eq("rr3_f_vld", F_R_DATA_VALID, 1);
        check_eq("rr3_d_vld", D_R_DATA_VALID, 0);
        check_eq("rr3_f_data", F_R_DATA, f_exp);
        check_eq("rr3_d_data", D_R_DATA, d_exp);
        F_R_ADDR_VALID = 1'b0;
        D_R_ADDR_VALID = 1'b0;
        tick();
        check_eq("rr_end_busy", BUSY, 0);

        // Address change and valid drop during WAIT; memory strobe also held through RESP
        D_R_ADDR       = 64'h200;
        D_R_ADDR_VALID = 1'b1;
        tick();
        check_eq("dw_m_addr", M_R_ADDR, 64'h200);
        D_R_ADDR = 64'h300;
        tick();
        check_eq("dw_m_addr_hold", M_R_ADDR, 64'h200);
        check_eq("dw_m_vld_hold", M_R_ADDR_VALID, 1);
        D_R_ADDR_VALID = 1'b0;
        tick();
        check_eq("dw_m_addr_hold2", M_R_ADDR, 64'h200);
        M_R_DATA       = line_55;
        M_R_DATA_VALID = 1'b1;
        tick();
        d_exp = line_55;
        check_eq("dw_d_vld", D_R_DATA_VALID, 1);
        check_eq("dw_d_data", D_R_DATA, d_exp);
        check_eq("dw_f_vld", F_R_DATA_VALID, 0);
        M_R_DATA = line_66;
        tick();
        M_R_DATA_VALID = 1'b0;
        check_eq("dw_resp_ign_d_data", D_R_DATA, d_exp);
        check_eq("dw_resp_ign_f_data", F_R_DATA, f_exp);
        check_idle_outputs("dw_end");

        // Spurious memory strobe in IDLE
        M_R_DATA       = line_77;
        M_R_DATA_VALID = 1'b1;
        tick();
        tick();
        M_R_DATA_VALID = 1'b0;
        check_idle_outputs("spur");
        check_eq("spur_f_data", F_R_DATA, f_exp);
        check_eq("spur_d_data", D_R_DATA, d_exp);

        // Asynchronous reset in the middle of WAIT
        F_R_ADDR       = 64'h1234;
        F_R_ADDR_VALID = 1'b1;
        tick();
        check_eq("ar_m_vld", M_R_ADDR_VALID, 1);
        #2;
        reset = 1'b0;
        #1;
        check_idle_outputs("ar_now");
        check_eq("ar_f_data", F_R_DATA, 0);
        check_eq("ar_d_data", D_R_DATA, 0);
        F_R_ADDR_VALID = 1'b0;
        tick();
        reset = 1'b1;
        M_R_DATA       = line_aa;
        M_R_DATA_VALID = 1'b1;
        tick();
        M_R_DATA_VALID = 1'b0;
        check_idle_outputs("ar_late");
        check_eq("ar_late_f_data", F_R_DATA, 0);
        tick();
        check_eq("ar_late2_f_vld", F_R_DATA_VALID, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
